uart_rx_ctrl: RTL
=================

# uart_rx_ctrl

UART receive sequencer that drives the RX baud-rate generator. It synchronises the asynchronous serial line and detects the start bit. It enables the baud generator through `band_sig` and samples each bit on the `clock_bps` mid-bit pulse. It checks the stop bit and presents each received byte on a valid/ready interface to the downstream command/weight loader of the accelerator.

## Interface
- `DATA_BITS`, default 8: data bits per frame, LSB first; no parity.
- `SYNC_STAGES`, default 2: flip-flop stages on `rx`; minimum 2.
- `clock` input 1: system clock; reset `reset`, synchronous, active-high; clock `clock`.
- `reset` input 1: synchronous, active-high.
- `rx` input 1: asynchronous serial line, idle high.
- `clock_bps` input 1: one-cycle mid-bit sample pulse from the baud generator.
- `band_sig` output 1: baud generator enable; low reloads the generator to its half-bit phase.
- `rx_data` output DATA_BITS: received byte; stable while `rx_valid` is high.
- `rx_valid` output 1: byte available; held until accepted.
- `rx_ready` input 1: consumer accepts on `rx_valid && rx_ready`.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `overrun` output 1: sticky; a good frame was dropped because the output buffer was full.
- `err_clr` input 1: clears `overrun`.
- `busy` output 1: high in any state other than IDLE.

## Operation
- `rx` passes through SYNC_STAGES flops, all reset to 1, giving `rx_s`. A further flop gives `rx_d`. A start edge is `rx_d==1 && rx_s==0`.
- State machine with states IDLE, START, DATA and STOP. It is encoded in 2 bits. `bit_cnt` is a counter of clog2(DATA_BITS) bits.
- IDLE: `band_sig`=0. A start edge moves the FSM to START and sets `band_sig`=1. `clock_bps` is ignored in IDLE.
- START, on `clock_bps`:
  - `rx_s`==0: go to DATA, clear `bit_cnt`.
  - `rx_s`==1: the start was a glitch. Return to IDLE, set `band_sig`=0, flag no error.
- DATA, on `clock_bps`: shift right, inserting `rx_s` at the MSB of the shift register. Increment `bit_cnt`. On the DATA_BITS-th sample, go to STOP.
- STOP, on `clock_bps`:
  - Always return to IDLE and set `band_sig`=0.
  - `rx_s`==1 with the buffer free, or freed this cycle by a handshake: load `rx_data` from the shift register and set `rx_valid`=1.
  - `rx_s`==1 with the buffer full and no handshake: keep the old `rx_data`/`rx_valid` and set `overrun`=1.
  - `rx_s`==0: pulse `frame_err` for one cycle, discard the byte, leave `rx_valid` unchanged.
- A handshake with no same-cycle load sets `rx_valid`=0. A same-cycle load wins and `rx_valid` stays 1.
- `overrun` is cleared by `err_clr`. If a set and a clear occur in the same cycle, set wins.
- IDLE re-arms only on a fresh high-to-low edge. A line held low (break) after a framing error does not start a new frame.

## Timing
- Reset values:
  - State IDLE; `band_sig`, `rx_valid`, `frame_err`, `overrun` and `busy` are 0.
  - `rx_data` and the shift register are 0; the sync flops and `rx_d` are 1.
- Reset mid-frame aborts the frame and produces no `rx_valid`.
- From an `rx` falling edge to `band_sig` high: SYNC_STAGES+1 cycles.
- All outputs are registered. `rx_valid` and `frame_err` assert, and `band_sig` deasserts, on the edge after the stop-bit `clock_bps` pulse.
- The STOP→IDLE transition happens at mid stop bit. The remaining half stop bit covers the re-arm, so back-to-back frames with one stop bit are received.
- The block does not depend on the baud count. It reacts only to `clock_bps`, which must be at least 2 cycles apart.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants `RX_IDLE`, `RX_START`, `RX_DATA`, `RX_STOP`.
  - Default `DATA_BITS`.
  - Baud constants shared with `uart_rx_band_gen`: `SYS_RATE`, `BAND_RATE`, `CNT_BAND`.
- One sub-module, `uart_rx_sync`, a parameterised multi-flop synchroniser with reset value 1.
- `uart_rx_band_gen` is instantiated beside this block in `uart_rx_top`, not inside it.

## Test plan
All scenarios use `uart_rx_band_gen` at CNT_BAND=135 and a 136-cycle bit period.
- Frame 0xA5, stop bit 1, `rx_ready`=1 → one `rx_valid` cycle with `rx_data`=0xA5; `frame_err`=0; `band_sig` falls on the same edge.
- Frame 0x3C with stop bit 0 → `frame_err` pulses for exactly 1 cycle; `rx_valid` stays 0. Then `rx` is held low for 2000 cycles → `busy` stays 0.
- 20-cycle low glitch → `band_sig` rises, then falls after the first `clock_bps`; no `rx_valid`, no `frame_err`.
- `rx_ready`=0, send 0x11 then 0x22 → `rx_data` stays 0x11 and `overrun`=1. Raise `rx_ready` → one handshake. `err_clr` → `overrun`=0.
- Assert `reset` after 4 data bits of 0x77 → all outputs return to reset values. A following 0x5A frame is received correctly.
- Back-to-back 0x00 then 0xFF, one stop bit each, `rx_ready`=1 → both bytes delivered in order, no errors.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: state type, default frame width, baud constants.
package uart_pkg;

  localparam int DEF_DATA_BITS = 8;

  // Baud constants shared with uart_rx_band_gen (136 clocks per bit).
  localparam int SYS_RATE  = 15_667_200;
  localparam int BAND_RATE = 115_200;
  localparam int CNT_BAND  = SYS_RATE / BAND_RATE - 1;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Received-byte valid/ready channel.
//   rx_data  : received byte, stable while rx_valid
//   rx_valid : byte available, held until accepted
//   rx_ready : consumer accepts on rx_valid && rx_ready
interface uart_rx_ctrl_if
  import uart_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (output rx_data, output rx_valid, input rx_ready);
  modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous level; all stages reset to 1.
//   clock, reset : system clock, synchronous active-high reset
//   d            : asynchronous input
//   q            : synchronised output
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clock) begin
    if (reset) sync_q <= '1;
    else       sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];
endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer driving the RX baud generator.
//   clock, reset : system clock, synchronous active-high reset
//   rx           : asynchronous serial line, idle high
//   clock_bps    : mid-bit sample pulse from the baud generator
//   band_sig     : baud generator enable (low reloads it to half-bit phase)
//   frame_err    : one-cycle pulse on a low stop bit
//   overrun      : sticky, good frame dropped while buffer full
//   err_clr      : clears overrun
//   busy         : FSM not idle
//   rx_bus       : received-byte valid/ready channel
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DEF_DATA_BITS,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            rx,
  input  logic            clock_bps,
  output logic            band_sig,
  output logic            frame_err,
  output logic            overrun,
  input  logic            err_clr,
  output logic            busy,
  uart_rx_ctrl_if.master  rx_bus
);
  localparam int CW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  rx_state_e            state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 band_q, band_d;
  logic                 busy_q, busy_d;
  logic                 rx_s, rx_d_q;
  logic                 start_edge, hs;

  uart_rx_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  // Edge, not level: a line held low after a framing error never re-arms.
  assign start_edge = rx_d_q & ~rx_s;
  assign hs         = valid_q & rx_bus.rx_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = hs ? 1'b0 : valid_q;
    ferr_d  = 1'b0;
    ovr_d   = err_clr ? 1'b0 : ovr_q;
    unique case (state_q)
      RX_IDLE: begin
        if (start_edge) state_d = RX_START;
      end
      RX_START: begin
        if (clock_bps) begin
          if (!rx_s) begin
            state_d = RX_DATA;
            cnt_d   = '0;
          end else begin
            state_d = RX_IDLE;
          end
        end
      end
      RX_DATA: begin
        if (clock_bps) begin
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_BITS - 1)) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (clock_bps) begin
          state_d = RX_IDLE;
          if (rx_s) begin
            // A same-cycle handshake frees the buffer, so the load wins.
            if (!valid_q || hs) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d = 1'b1;
          end
        end
      end
      default: state_d = RX_IDLE;
    endcase
    band_d = (state_d != RX_IDLE);
    busy_d = (state_d != RX_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      band_q  <= 1'b0;
      busy_q  <= 1'b0;
      rx_d_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      band_q  <= band_d;
      busy_q  <= busy_d;
      rx_d_q  <= rx_s;
    end
  end

  assign band_sig        = band_q;
  assign busy            = busy_q;
  assign frame_err       = ferr_q;
  assign overrun         = ovr_q;
  assign rx_bus.rx_data  = data_q;
  assign rx_bus.rx_valid = valid_q;
endmodule
